// File: rtl/exc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : exc_pkg
// Description : Shared constants for the writeback exception unit: pipeline
//               exception source indices and the source-to-code mapping.
// Revision    : 1.0 - initial release
// ============================================================================
package exc_pkg;

    // Pipeline exception sources, in priority order (lowest index wins)
    localparam int SRC_ADD  = 0;  // add r-type
    localparam int SRC_ADDI = 1;  // addi
    localparam int SRC_SUB  = 2;  // sub r-type

    // Exception code written to the status register for pipeline source idx.
    // Code 0 is reserved for "no exception", hence the +1 offset.
    function automatic int unsigned code_of(input int unsigned idx);
        return idx + 32'd1;
    endfunction

endpackage : exc_pkg
`default_nettype wire

// File: rtl/exc_pending_slot.sv
`default_nettype none
// ============================================================================
// Module      : exc_pending_slot
// Description : One-entry holding buffer for late multdiv exceptions. A load
//               into a full slot is dropped and flagged as an overrun, unless
//               the slot is being emptied on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module exc_pending_slot #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_code,
    input  logic              take,
    input  logic              clr,
    output logic              full,
    output logic [DATA_W-1:0] code,
    output logic              overrun
);

    logic              full_q,    full_d;
    logic [DATA_W-1:0] code_q,    code_d;
    logic              overrun_q, overrun_d;

    // Next-state: take empties, load fills; a load that finds the slot still
    // occupied keeps the old code and raises the sticky overrun instead.
    always_comb begin
        full_d    = full_q;
        code_d    = code_q;
        overrun_d = overrun_q;
        if (clr) begin
            overrun_d = 1'b0;
        end
        if (take) begin
            full_d = 1'b0;
        end
        if (load) begin
            if (full_q && !take) begin
                overrun_d = 1'b1;
            end else begin
                full_d = 1'b1;
                code_d = load_code;
            end
        end
    end

    // Slot state registers; reset discards any buffered exception
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            full_q    <= 1'b0;
            code_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            full_q    <= full_d;
            code_q    <= code_d;
            overrun_q <= overrun_d;
        end
    end

    assign full    = full_q;
    assign code    = code_q;
    assign overrun = overrun_q;

endmodule : exc_pending_slot
`default_nettype wire

// File: rtl/exc_writeback_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exc_writeback_ctrl
// Description : Writeback-stage exception unit. ALU overflow on a flagged op
//               type redirects the writeback to the status register; late
//               multdiv exceptions wait in a one-entry slot and are injected
//               on the next writeback bubble. Registered output stage, sticky
//               status code and saturating exception counter.
// Revision    : 1.0 - initial release
// ============================================================================
module exc_writeback_ctrl
    import exc_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_W      = 5,
    parameter int STATUS_REG = 30,
    parameter int N_SRC      = 3,
    parameter int MD_CODE_W  = 3,
    parameter int CNT_W      = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 in_valid,
    input  logic                 in_we,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [REG_W-1:0]     in_reg,
    input  logic [N_SRC-1:0]     op_sel,
    input  logic                 ovf,
    input  logic                 md_exc,
    input  logic [MD_CODE_W-1:0] md_code,
    input  logic                 clr_status,
    output logic                 out_we,
    output logic [DATA_W-1:0]    out_data,
    output logic [REG_W-1:0]     out_reg,
    output logic [DATA_W-1:0]    status_code,
    output logic [CNT_W-1:0]     exc_count,
    output logic                 md_overrun
);

    // Largest code is N_SRC + 2^MD_CODE_W; it must fit in the data path
    generate
        if ((64'(N_SRC) + (64'd1 << MD_CODE_W)) >= (64'd1 << DATA_W)) begin : g_width_check
            $error("exc_writeback_ctrl: exception codes do not fit in DATA_W");
        end
    endgenerate

    logic              w_wb;
    logic              w_hit;
    logic              w_inject;
    logic [DATA_W-1:0] w_hit_code;
    logic [DATA_W-1:0] w_md_code;
    logic              w_slot_full;
    logic [DATA_W-1:0] w_slot_code;
    int unsigned       w_hit_idx;

    logic              out_we_q,      out_we_d;
    logic [DATA_W-1:0] out_data_q,    out_data_d;
    logic [REG_W-1:0]  out_reg_q,     out_reg_d;
    logic [DATA_W-1:0] status_code_q, status_code_d;
    logic [CNT_W-1:0]  exc_count_q,   exc_count_d;

    assign w_wb      = in_valid & in_we;
    assign w_hit     = w_wb & ovf & (|op_sel);
    // A pending code may only use the write port when no instruction needs it
    assign w_inject  = !stall && w_slot_full && !w_wb;
    assign w_md_code = DATA_W'(N_SRC + 1) + DATA_W'(md_code);

    // Priority encoder: lowest set bit of op_sel selects the exception source
    always_comb begin
        w_hit_idx = 0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (op_sel[i]) begin
                w_hit_idx = i;
            end
        end
        w_hit_code = DATA_W'(code_of(w_hit_idx));
    end

    // md_exc is a one-cycle pulse, so the slot captures it even while stalled
    exc_pending_slot #(
        .DATA_W (DATA_W)
    ) u_slot (
        .clock     (clock),
        .reset     (reset),
        .load      (md_exc),
        .load_code (w_md_code),
        .take      (w_inject),
        .clr       (clr_status && !stall),
        .full      (w_slot_full),
        .code      (w_slot_code),
        .overrun   (md_overrun)
    );

    // Writeback mux plus status/counter update; stall holds everything
    always_comb begin
        logic              exc_wr;
        logic [DATA_W-1:0] exc_code;
        logic [CNT_W-1:0]  cnt_base;

        out_we_d      = out_we_q;
        out_data_d    = out_data_q;
        out_reg_d     = out_reg_q;
        status_code_d = status_code_q;
        exc_count_d   = exc_count_q;
        exc_wr        = 1'b0;
        exc_code      = '0;
        cnt_base      = clr_status ? '0 : exc_count_q;

        if (!stall) begin
            out_we_d   = w_wb;
            out_data_d = in_data;
            out_reg_d  = in_reg;
            if (w_hit) begin
                exc_wr   = 1'b1;
                exc_code = w_hit_code;
            end else if (w_inject) begin
                exc_wr   = 1'b1;
                exc_code = w_slot_code;
            end
            if (exc_wr) begin
                out_we_d   = 1'b1;
                out_data_d = exc_code;
                out_reg_d  = REG_W'(STATUS_REG);
            end

            // Clear first, then let a same-cycle exception land on top of it
            if (clr_status) begin
                status_code_d = '0;
                exc_count_d   = '0;
            end
            if (exc_wr) begin
                status_code_d = exc_code;
                exc_count_d   = (cnt_base == {CNT_W{1'b1}}) ? cnt_base : cnt_base + 1'b1;
            end
        end
    end

    // Output stage and sticky status registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_we_q      <= 1'b0;
            out_data_q    <= '0;
            out_reg_q     <= '0;
            status_code_q <= '0;
            exc_count_q   <= '0;
        end else begin
            out_we_q      <= out_we_d;
            out_data_q    <= out_data_d;
            out_reg_q     <= out_reg_d;
            status_code_q <= status_code_d;
            exc_count_q   <= exc_count_d;
        end
    end

    assign out_we      = out_we_q;
    assign out_data    = out_data_q;
    assign out_reg     = out_reg_q;
    assign status_code = status_code_q;
    assign exc_count   = exc_count_q;

endmodule : exc_writeback_ctrl
`default_nettype wire

// File: tb/tb_exc_writeback_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_exc_writeback_ctrl
// Description : Directed self-checking bench for exc_writeback_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exc_writeback_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        in_valid;
    logic        in_we;
    logic [31:0] in_data;
    logic [4:0]  in_reg;
    logic [2:0]  op_sel;
    logic        ovf;
    logic        md_exc;
    logic [2:0]  md_code;
    logic        clr_status;
    logic        out_we;
    logic [31:0] out_data;
    logic [4:0]  out_reg;
    logic [31:0] status_code;
    logic [7:0]  exc_count;
    logic        md_overrun;

    int n_checks = 0;
    int n_errors = 0;

    exc_writeback_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .in_valid    (in_valid),
        .in_we       (in_we),
        .in_data     (in_data),
        .in_reg      (in_reg),
        .op_sel      (op_sel),
        .ovf         (ovf),
        .md_exc      (md_exc),
        .md_code     (md_code),
        .clr_status  (clr_status),
        .out_we      (out_we),
        .out_data    (out_data),
        .out_reg     (out_reg),
        .status_code (status_code),
        .exc_count   (exc_count),
        .md_overrun  (md_overrun)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        stall = 0; in_valid = 0; in_we = 0; in_data = 0; in_reg = 0;
        op_sel = 0; ovf = 0; md_exc = 0; md_code = 0; clr_status = 0;
    endtask

    task automatic drive_wb(input logic [4:0] r, input logic [31:0] d);
        in_valid = 1; in_we = 1; in_reg = r; in_data = d;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 0;
        #3;
        n_checks++; if (out_we !== 1'b0) begin n_errors++; $display("FAIL reset_out_we got %0h want 0", out_we); end
        n_checks++; if (out_data !== 32'd0) begin n_errors++; $display("FAIL reset_out_data got %0h want 0", out_data); end
        n_checks++; if (out_reg !== 5'd0) begin n_errors++; $display("FAIL reset_out_reg got %0d want 0", out_reg); end
        n_checks++; if (status_code !== 32'd0) begin n_errors++; $display("FAIL reset_status got %0d want 0", status_code); end
        n_checks++; if (exc_count !== 8'd0) begin n_errors++; $display("FAIL reset_count got %0d want 0", exc_count); end
        n_checks++; if (md_overrun !== 1'b0) begin n_errors++; $display("FAIL reset_overrun got %0d want 0", md_overrun); end
        @(negedge clock);
        reset = 1;
        step();
    endtask

    task automatic test_add_ovf();
        drive_wb(5'd7, 32'd5); op_sel = 3'b001; ovf = 1;
        step();
        n_checks++; if (out_we !== 1'b1) begin n_errors++; $display("FAIL add_we got %0d want 1", out_we); end
        n_checks++; if (out_reg !== 5'd30) begin n_errors++; $display("FAIL add_reg got %0d want 30", out_reg); end
        n_checks++; if (out_data !== 32'd1) begin n_errors++; $display("FAIL add_data got %0d want 1", out_data); end
        n_checks++; if (exc_count !== 8'd1) begin n_errors++; $display("FAIL add_count got %0d want 1", exc_count); end
        n_checks++; if (status_code !== 32'd1) begin n_errors++; $display("FAIL add_status got %0d want 1", status_code); end
        drive_idle();
    endtask

    task automatic test_priority();
        drive_wb(5'd7, 32'd5); op_sel = 3'b110; ovf = 1;
        step();
        n_checks++; if (out_data !== 32'd2) begin n_errors++; $display("FAIL prio_data got %0d want 2", out_data); end
        n_checks++; if (exc_count !== 8'd2) begin n_errors++; $display("FAIL prio_count got %0d want 2", exc_count); end
        drive_wb(5'd9, 32'h1234); op_sel = 3'b110; ovf = 0;
        step();
        n_checks++; if (out_we !== 1'b1) begin n_errors++; $display("FAIL pass_we got %0d want 1", out_we); end
        n_checks++; if (out_reg !== 5'd9) begin n_errors++; $display("FAIL pass_reg got %0d want 9", out_reg); end
        n_checks++; if (out_data !== 32'h1234) begin n_errors++; $display("FAIL pass_data got %0h want 1234", out_data); end
        n_checks++; if (exc_count !== 8'd2) begin n_errors++; $display("FAIL pass_count got %0d want 2", exc_count); end
        n_checks++; if (status_code !== 32'd2) begin n_errors++; $display("FAIL pass_status got %0d want 2", status_code); end
        drive_idle();
    endtask

    task automatic test_md_held();
        for (int i = 0; i < 3; i++) begin
            drive_wb(5'd3, 32'd10 + 32'(i));
            md_exc = (i == 0); md_code = 3'd2;
            step();
            n_checks++; if (out_reg !== 5'd3) begin n_errors++; $display("FAIL held_reg[%0d] got %0d want 3", i, out_reg); end
            n_checks++; if (out_data !== 32'd10 + 32'(i)) begin n_errors++; $display("FAIL held_data[%0d] got %0d want %0d", i, out_data, 10 + i); end
        end
        drive_idle();
        step();
        n_checks++; if (out_we !== 1'b1) begin n_errors++; $display("FAIL inject_we got %0d want 1", out_we); end
        n_checks++; if (out_reg !== 5'd30) begin n_errors++; $display("FAIL inject_reg got %0d want 30", out_reg); end
        n_checks++; if (out_data !== 32'd6) begin n_errors++; $display("FAIL inject_data got %0d want 6", out_data); end
        n_checks++; if (status_code !== 32'd6) begin n_errors++; $display("FAIL inject_status got %0d want 6", status_code); end
        n_checks++; if (exc_count !== 8'd3) begin n_errors++; $display("FAIL inject_count got %0d want 3", exc_count); end
        step();
        n_checks++; if (out_we !== 1'b0) begin n_errors++; $display("FAIL slot_empty_we got %0d want 0", out_we); end
    endtask

    task automatic test_overrun();
        drive_wb(5'd4, 32'd1); md_exc = 1; md_code = 3'd1;
        step();
        md_code = 3'd4;
        step();
        n_checks++; if (md_overrun !== 1'b1) begin n_errors++; $display("FAIL overrun_set got %0d want 1", md_overrun); end
        drive_idle();
        step();
        n_checks++; if (out_data !== 32'd5) begin n_errors++; $display("FAIL overrun_keep_old got %0d want 5", out_data); end
        n_checks++; if (exc_count !== 8'd4) begin n_errors++; $display("FAIL overrun_count got %0d want 4", exc_count); end
        step();
        n_checks++; if (out_we !== 1'b0) begin n_errors++; $display("FAIL overrun_no_second got %0d want 0", out_we); end
        clr_status = 1;
        step();
        clr_status = 0;
        n_checks++; if (md_overrun !== 1'b0) begin n_errors++; $display("FAIL clr_overrun got %0d want 0", md_overrun); end
        n_checks++; if (exc_count !== 8'd0) begin n_errors++; $display("FAIL clr_count got %0d want 0", exc_count); end
        n_checks++; if (status_code !== 32'd0) begin n_errors++; $display("FAIL clr_status got %0d want 0", status_code); end
    endtask

    task automatic test_same_cycle_refill();
        drive_wb(5'd4, 32'd1); md_exc = 1; md_code = 3'd0;
        step();
        drive_idle(); md_exc = 1; md_code = 3'd7;
        step();
        n_checks++; if (out_data !== 32'd4) begin n_errors++; $display("FAIL refill_first got %0d want 4", out_data); end
        n_checks++; if (md_overrun !== 1'b0) begin n_errors++; $display("FAIL refill_overrun got %0d want 0", md_overrun); end
        drive_idle();
        step();
        n_checks++; if (out_data !== 32'd11) begin n_errors++; $display("FAIL refill_second got %0d want 11", out_data); end
        n_checks++; if (exc_count !== 8'd2) begin n_errors++; $display("FAIL refill_count got %0d want 2", exc_count); end
        step();
        n_checks++; if (out_we !== 1'b0) begin n_errors++; $display("FAIL refill_empty got %0d want 0", out_we); end
    endtask

    task automatic test_saturate_stall();
        clr_status = 1;
        step();
        clr_status = 0;
        drive_wb(5'd2, 32'd9); op_sel = 3'b100; ovf = 1;
        for (int i = 0; i < 255; i++) step();
        n_checks++; if (exc_count !== 8'd255) begin n_errors++; $display("FAIL sat_255 got %0d want 255", exc_count); end
        step();
        n_checks++; if (exc_count !== 8'd255) begin n_errors++; $display("FAIL sat_hold got %0d want 255", exc_count); end
        n_checks++; if (status_code !== 32'd3) begin n_errors++; $display("FAIL sat_status got %0d want 3", status_code); end
        stall = 1; op_sel = 3'b001; in_data = 32'd77; md_exc = 1; md_code = 3'd0;
        step();
        md_exc = 0;
        step();
        n_checks++; if (out_data !== 32'd3) begin n_errors++; $display("FAIL stall_data got %0d want 3", out_data); end
        n_checks++; if (out_reg !== 5'd30) begin n_errors++; $display("FAIL stall_reg got %0d want 30", out_reg); end
        n_checks++; if (status_code !== 32'd3) begin n_errors++; $display("FAIL stall_status got %0d want 3", status_code); end
        drive_idle();
        step();
        n_checks++; if (out_data !== 32'd4) begin n_errors++; $display("FAIL stall_capture got %0d want 4", out_data); end
        n_checks++; if (exc_count !== 8'd255) begin n_errors++; $display("FAIL stall_count got %0d want 255", exc_count); end
    endtask

    task automatic test_reset_mid();
        drive_wb(5'd4, 32'd1); md_exc = 1; md_code = 3'd3;
        step();
        drive_idle();
        #2 reset = 0;
        #1;
        n_checks++; if (out_we !== 1'b0) begin n_errors++; $display("FAIL rst_mid_we got %0d want 0", out_we); end
        n_checks++; if (exc_count !== 8'd0) begin n_errors++; $display("FAIL rst_mid_count got %0d want 0", exc_count); end
        n_checks++; if (status_code !== 32'd0) begin n_errors++; $display("FAIL rst_mid_status got %0d want 0", status_code); end
        @(negedge clock);
        reset = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (out_we !== 1'b0) begin n_errors++; $display("FAIL rst_no_inject[%0d] got %0d want 0", i, out_we); end
        end
        n_checks++; if (md_overrun !== 1'b0) begin n_errors++; $display("FAIL rst_overrun got %0d want 0", md_overrun); end
    endtask

    initial begin
        test_reset();
        test_add_ovf();
        test_priority();
        test_md_held();
        test_overrun();
        test_same_cycle_refill();
        test_saturate_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_exc_writeback_ctrl
`default_nettype wire
